// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, bit shifting on device clocks, ACK check.
// Optional build macro PS2_TX_RETRY_EN retries a failed frame once before reporting error.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES) + 1;
   localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t        state, state_next;
   logic [2:0]    clk_sync;
   logic [1:0]    data_sync;
   logic [9:0]    frame, frame_next;
   logic [3:0]    bit_cnt, bit_cnt_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          clk_oe_next, data_oe_next, done_next, error_next;
   logic          fall, line_idle, fail, timed;
`ifdef PS2_TX_RETRY_EN
   logic          retry_used, retry_used_next;
`endif

   assign fall      = clk_sync[2] & ~clk_sync[1];
   assign line_idle = clk_sync[1] & data_sync[1];
   assign tx_ready  = (state == IDLE);
   assign busy      = ~tx_ready;
   assign timed     = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         clk_sync    <= 3'b111;
         data_sync   <= 2'b11;
         frame       <= '0;
         bit_cnt     <= '0;
         cnt         <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_used  <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         clk_sync    <= {clk_sync[1:0], ps2_clk_in};
         data_sync   <= {data_sync[0], ps2_data_in};
         frame       <= frame_next;
         bit_cnt     <= bit_cnt_next;
         cnt         <= cnt_next;
         ps2_clk_oe  <= clk_oe_next;
         ps2_data_oe <= data_oe_next;
         done        <= done_next;
         error       <= error_next;
`ifdef PS2_TX_RETRY_EN
         retry_used  <= retry_used_next;
`endif
      end
   end

   // Line enables are registered from the next state so they change on the same edge as the state.
   always_comb begin
      state_next   = state;
      frame_next   = frame;
      bit_cnt_next = bit_cnt;
      cnt_next     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      data_oe_next = ps2_data_oe;
      clk_oe_next  = 1'b0;
      done_next    = 1'b0;
      error_next   = 1'b0;
      fail         = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_used_next = retry_used;
`endif
      case (state)
         IDLE: begin
            if (tx_valid) begin
               frame_next = {1'b1, ~^tx_data, tx_data};
               cnt_next   = '0;
               state_next = INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_used_next = 1'b0;
`endif
            end
         end
         INHIBIT: begin
            if (cnt == INHIBIT_LAST) state_next = REQ;
         end
         REQ: begin
            cnt_next     = '0;
            bit_cnt_next = '0;
            state_next   = SHIFT;
         end
         SHIFT: begin
            if (fall) begin
               data_oe_next = ~frame[bit_cnt];
               bit_cnt_next = bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) state_next = ACK;
            end
         end
         ACK: begin
            if (fall) begin
               if (!data_sync[1]) state_next = WAIT_IDLE;
               else               fail       = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (line_idle) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // A timeout overrides whatever the frame logic decided this cycle, including a late done.
      if (timed && cnt >= TIMEOUT_LAST) begin
         fail      = 1'b1;
         done_next = 1'b0;
      end

      if (fail) begin
`ifdef PS2_TX_RETRY_EN
         if (!retry_used) begin
            state_next      = INHIBIT;
            cnt_next        = '0;
            retry_used_next = 1'b1;
         end else begin
            state_next = IDLE;
            error_next = 1'b1;
         end
`else
         state_next = IDLE;
         error_next = 1'b1;
`endif
      end

      clk_oe_next = (state_next == INHIBIT) || (state_next == REQ);
      case (state_next)
         REQ:     data_oe_next = 1'b1;
         SHIFT:   data_oe_next = data_oe_next;
         default: data_oe_next = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a tiny receiver for loopback.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INHIBIT = 10;
   localparam int TIMEOUT = 4000;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 2;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       busy, done, error;
   logic       dev_clk_low, dev_data_low;
   logic       clk_line, data_line;

   assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign data_line = ~(ps2_data_oe | dev_data_low);

   int n_checks = 0;
   int n_fails  = 0;

   int cyc, done_cnt, err_cnt, both_cnt, inhib_cycles, inhib_phases, req_cycles, oe_cycles;
   int req_cyc, err_cyc;
   bit prev_inhib;

   int         dev_mode;
   bit         dev_abort, dev_busy;
   int         dev_rises;
   logic [9:0] dev_bits;
   logic       dev_start;

   bit          rx_en, rx_ready;
   int          rx_count;
   logic [10:0] rx_shift;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .ps2_clk_in (clk_line),
      .ps2_data_in(data_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #2.5 clk = ~clk;

   initial begin
      cyc = 0; prev_inhib = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) done_cnt++;
         if (error === 1'b1) begin err_cnt++; err_cyc = cyc; end
         if (done === 1'b1 && error === 1'b1) both_cnt++;
         if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) begin
            inhib_cycles++;
            if (!prev_inhib) inhib_phases++;
         end
         prev_inhib = (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0);
         if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) begin req_cycles++; req_cyc = cyc; end
         if (ps2_clk_oe === 1'b1 || ps2_data_oe === 1'b1) oe_cycles++;
      end
   end

   // Device: starts when clock is released with data low, samples on rising edges, ACKs on clock 11.
   initial begin
      int i;
      dev_clk_low = 0; dev_data_low = 0; dev_busy = 0; dev_rises = 0;
      dev_bits = '0; dev_start = 1'b1;
      forever begin
         @(negedge clk);
         if (dev_mode != 0 && !dev_abort && clk_line === 1'b1 && data_line === 1'b0) begin
            dev_busy = 1; dev_start = data_line; dev_rises = 0;
            #20;
            i = 1;
            while (i <= 11 && !dev_abort) begin
               dev_clk_low = 1; #30;
               dev_clk_low = 0;
               if (!dev_abort) begin
                  if (i <= 10) dev_bits[i-1] = data_line;
                  dev_rises = i;
                  if (i == 10 && dev_mode == 1) dev_data_low = 1;
               end
               if (i < 11) #30;
               i++;
            end
            dev_clk_low = 0; dev_data_low = 0; dev_busy = 0;
         end
      end
   end

   initial begin
      rx_count = 0; rx_ready = 0; rx_shift = '0;
      forever begin
         @(negedge clk_line);
         if (rx_en) begin
            rx_shift = {data_line, rx_shift[10:1]};
            rx_count++;
            if (rx_count == 11) rx_ready = 1;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats;
      done_cnt = 0; err_cnt = 0; both_cnt = 0; inhib_cycles = 0; inhib_phases = 0;
      req_cycles = 0; oe_cycles = 0; req_cyc = 0; err_cyc = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      tick;
      tx_data = b; tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 20000) begin tick; n++; end
      tick;
      tx_valid = 1'b0;
   endtask

   task automatic wait_report(input int budget, output bit ok);
      int base, n;
      base = done_cnt + err_cnt;
      n = 0;
      while (done_cnt + err_cnt == base && n < budget) begin tick; n++; end
      ok = (n < budget);
   endtask

   task automatic test_reset;
      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_mode = 0; dev_abort = 0; rx_en = 0;
      repeat (5) tick;
      n_checks++; if (tx_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (error !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
      n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
      n_checks++; if (ps2_data_oe !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
      rst = 1'b0;
      repeat (3) tick;
   endtask

   task automatic test_led_cmd;
      bit ok;
      clear_stats(); dev_mode = 1;
      send_byte(8'hED);
      n_checks++; if (tx_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL led_ready_drop: got %b expected 0", tx_ready); end
      wait_report(2000, ok);
      n_checks++; if (!ok) begin n_fails++; $display("[TB] FAIL led_wait: got no report expected done within 2000 cycles"); end
      repeat (20) tick;
      n_checks++; if (inhib_cycles !== INHIBIT) begin n_fails++; $display("[TB] FAIL led_inhibit_len: got %0d expected %0d", inhib_cycles, INHIBIT); end
      n_checks++; if (req_cycles !== 1) begin n_fails++; $display("[TB] FAIL led_req_len: got %0d expected 1", req_cycles); end
      n_checks++; if (dev_start !== 1'b0) begin n_fails++; $display("[TB] FAIL led_start: got %b expected 0", dev_start); end
      n_checks++; if (dev_bits[7:0] !== 8'hED) begin n_fails++; $display("[TB] FAIL led_data: got %h expected ed", dev_bits[7:0]); end
      n_checks++; if (dev_bits[8] !== 1'b1) begin n_fails++; $display("[TB] FAIL led_parity: got %b expected 1", dev_bits[8]); end
      n_checks++; if (dev_bits[9] !== 1'b1) begin n_fails++; $display("[TB] FAIL led_stop: got %b expected 1", dev_bits[9]); end
      n_checks++; if (done_cnt !== 1) begin n_fails++; $display("[TB] FAIL led_done_count: got %0d expected 1", done_cnt); end
      n_checks++; if (err_cnt !== 0) begin n_fails++; $display("[TB] FAIL led_error_count: got %0d expected 0", err_cnt); end
      n_checks++; if (tx_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL led_ready_back: got %b expected 1", tx_ready); end
   endtask

   task automatic test_back_to_back;
      int n;
      clear_stats(); dev_mode = 1;
      tick;
      tx_data = 8'h07; tx_valid = 1'b1;
      tick;
      n_checks++; if (tx_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_first_accept: got %b expected 0", tx_ready); end
      tx_data = 8'h00;
      n = 0;
      while (done_cnt == 0 && err_cnt == 0 && n < 2000) begin tick; n++; end
      n_checks++; if (done_cnt !== 1) begin n_fails++; $display("[TB] FAIL b2b_first_done: got %0d expected 1", done_cnt); end
      n_checks++; if (inhib_phases !== 1) begin n_fails++; $display("[TB] FAIL b2b_no_early_accept: got %0d expected 1", inhib_phases); end
      n_checks++; if (dev_bits[7:0] !== 8'h07) begin n_fails++; $display("[TB] FAIL b2b_data0: got %h expected 07", dev_bits[7:0]); end
      n_checks++; if (dev_bits[8] !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_parity0: got %b expected 0", dev_bits[8]); end
      tick;
      n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_second_accept: got %b expected 1", busy); end
      tx_valid = 1'b0;
      n = 0;
      while (done_cnt < 2 && err_cnt == 0 && n < 2000) begin tick; n++; end
      repeat (5) tick;
      n_checks++; if (done_cnt !== 2) begin n_fails++; $display("[TB] FAIL b2b_second_done: got %0d expected 2", done_cnt); end
      n_checks++; if (dev_bits[7:0] !== 8'h00) begin n_fails++; $display("[TB] FAIL b2b_data1: got %h expected 00", dev_bits[7:0]); end
      n_checks++; if (dev_bits[8] !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_parity1: got %b expected 1", dev_bits[8]); end
      n_checks++; if (err_cnt !== 0) begin n_fails++; $display("[TB] FAIL b2b_errors: got %0d expected 0", err_cnt); end
   endtask

   task automatic test_nack;
      bit ok;
      clear_stats(); dev_mode = 2;
      send_byte(8'h55);
      wait_report(1000, ok);
      n_checks++; if (!ok) begin n_fails++; $display("[TB] FAIL nack_wait: got no report expected error within 1000 cycles"); end
      repeat (20) tick;
      n_checks++; if (err_cnt !== 1) begin n_fails++; $display("[TB] FAIL nack_error: got %0d expected 1", err_cnt); end
      n_checks++; if (done_cnt !== 0) begin n_fails++; $display("[TB] FAIL nack_done: got %0d expected 0", done_cnt); end
      n_checks++; if (inhib_phases !== ATTEMPTS) begin n_fails++; $display("[TB] FAIL nack_attempts: got %0d expected %0d", inhib_phases, ATTEMPTS); end
      n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fails++; $display("[TB] FAIL nack_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
   endtask

   task automatic test_timeout;
      bit ok;
      clear_stats(); dev_mode = 0;
      send_byte(8'h12);
      wait_report(9000, ok);
      n_checks++; if (!ok) begin n_fails++; $display("[TB] FAIL timeout_wait: got no report expected error within 9000 cycles"); end
      tick;
      n_checks++; if (err_cnt !== 1) begin n_fails++; $display("[TB] FAIL timeout_error: got %0d expected 1", err_cnt); end
      n_checks++; if (done_cnt !== 0) begin n_fails++; $display("[TB] FAIL timeout_done: got %0d expected 0", done_cnt); end
      n_checks++; if (err_cyc - req_cyc < TIMEOUT || err_cyc - req_cyc > TIMEOUT + 2) begin
         n_fails++; $display("[TB] FAIL timeout_latency: got %0d expected %0d..%0d", err_cyc - req_cyc, TIMEOUT, TIMEOUT + 2);
      end
      n_checks++; if (inhib_phases !== ATTEMPTS) begin n_fails++; $display("[TB] FAIL timeout_attempts: got %0d expected %0d", inhib_phases, ATTEMPTS); end
      n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fails++; $display("[TB] FAIL timeout_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
   endtask

   task automatic test_reset_mid_frame;
      int n;
      bit ok;
      clear_stats(); dev_mode = 1;
      send_byte(8'h3C);
      n = 0;
      while (dev_rises < 4 && n < 2000) begin tick; n++; end
      n_checks++; if (dev_rises < 4) begin n_fails++; $display("[TB] FAIL midrst_reach: got %0d rises expected 4", dev_rises); end
      rst = 1'b1; dev_abort = 1;
      tick;
      n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fails++; $display("[TB] FAIL midrst_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
      n_checks++; if (tx_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL midrst_ready: got %b expected 1", tx_ready); end
      n_checks++; if ({done, error} !== 2'b00) begin n_fails++; $display("[TB] FAIL midrst_report: got %b expected 00", {done, error}); end
      rst = 1'b0;
      n = 0;
      while (dev_busy && n < 200) begin tick; n++; end
      dev_abort = 0;
      repeat (30) tick;
      n_checks++; if (done_cnt + err_cnt !== 0) begin n_fails++; $display("[TB] FAIL midrst_silent: got %0d reports expected 0", done_cnt + err_cnt); end
      send_byte(8'hFF);
      wait_report(2000, ok);
      repeat (10) tick;
      n_checks++; if (done_cnt !== 1 || err_cnt !== 0) begin n_fails++; $display("[TB] FAIL midrst_next_frame: got done=%0d error=%0d expected done=1 error=0", done_cnt, err_cnt); end
      n_checks++; if (dev_bits !== 10'b11_1111_1111) begin n_fails++; $display("[TB] FAIL midrst_next_bits: got %b expected 1111111111", dev_bits); end
   endtask

   task automatic test_loopback;
      bit ok;
      logic [10:0] reply;
      clear_stats(); dev_mode = 1;
      send_byte(8'hED);
      wait_report(2000, ok);
      repeat (10) tick;
      n_checks++; if (done_cnt !== 1) begin n_fails++; $display("[TB] FAIL loop_host_done: got %0d expected 1", done_cnt); end
      dev_mode = 0; clear_stats();
      rx_count = 0; rx_ready = 0; rx_en = 1;
      reply = {1'b1, 1'b1, 8'hFA, 1'b0};
      for (int i = 0; i < 11; i++) begin
         dev_data_low = ~reply[i]; #15;
         dev_clk_low = 1; #30;
         dev_clk_low = 0; #15;
      end
      dev_data_low = 0; rx_en = 0;
      repeat (10) tick;
      n_checks++; if (rx_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL loop_rx_ready: got %b expected 1", rx_ready); end
      n_checks++; if (rx_shift[8:1] !== 8'hFA) begin n_fails++; $display("[TB] FAIL loop_rx_data: got %h expected fa", rx_shift[8:1]); end
      n_checks++; if ({rx_shift[10], rx_shift[9], rx_shift[0]} !== 3'b110) begin n_fails++; $display("[TB] FAIL loop_rx_framing: got %b expected 110", {rx_shift[10], rx_shift[9], rx_shift[0]}); end
      n_checks++; if (oe_cycles !== 0) begin n_fails++; $display("[TB] FAIL loop_host_quiet: got %0d driven cycles expected 0", oe_cycles); end
      n_checks++; if (done_cnt + err_cnt !== 0) begin n_fails++; $display("[TB] FAIL loop_host_reports: got %0d expected 0", done_cnt + err_cnt); end
   endtask

   initial begin
      $display("[TB] start");
      clear_stats();
      test_reset();
      test_led_cmd();
      test_back_to_back();
      test_nack();
      test_timeout();
      test_reset_mid_frame();
      test_loopback();
      n_checks++; if (both_cnt !== 0) begin n_fails++; $display("[TB] FAIL done_error_overlap: got %0d expected 0", both_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
      $finish;
   end

endmodule
